vram_port_arbiter: RTL and testbench



---
 rtl/vram_port_arbiter_if.sv | 43 ++++
 rtl/vram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_vram_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// Signal bundle between the VRAM port arbiter and its surroundings:
// sync-generator counters, the write clients, the VRAM port and the
// colour stage.
interface vram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 15
);
  logic                      in_display;
  logic [10:0]               scan_x;
  logic [8:0]                scan_y;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic [DATA_W-1:0]         pixel;
  logic                      pixel_valid;

  // Arbiter side: takes counters, requests and read data, owns the port.
  modport slave (
    input  in_display, scan_x, scan_y,
    input  req, req_addr, req_data,
    input  mem_rdata,
    output gnt,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output pixel, pixel_valid
  );

  // Environment side: sync generator, clients, VRAM and colour stage.
  modport master (
    output in_display, scan_x, scan_y,
    output req, req_addr, req_data,
    output mem_rdata,
    input  gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  pixel, pixel_valid
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM owner. While the beam is in the active area the port
// performs scanout reads addressed from the sync counters; during
// blanking it hands out single-cycle write slots round-robin to the
// drawing clients. Scanout data comes back two edges after the counters
// were sampled.
module vram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 15,
  parameter int LINE_WORDS = 160,
  parameter int H_SHIFT    = 3,
  parameter int V_SHIFT    = 2
) (
  input logic                clk,
  input logic                rst_n,
  vram_port_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ARB  = 1'b0,
    SCAN = 1'b1
  } portState_t;

  portState_t         state;
  logic [PTR_W-1:0]   rrPtr;
  logic [NUM_REQ-1:0] gntQ;
  logic               memEnQ;
  logic               memWeQ;
  logic [ADDR_W-1:0]  memAddrQ;
  logic [DATA_W-1:0]  memWdataQ;
  logic               scanReadQ;
  logic [DATA_W-1:0]  pixelQ;
  logic               pixelValidQ;

  logic [NUM_REQ-1:0] eligible;
  logic               pickValid;
  logic [PTR_W-1:0]   pickIdx;
  logic [PTR_W-1:0]   cand;
  logic [ADDR_W-1:0]  scanAddr;
  logic [ADDR_W-1:0]  pickAddr;
  logic [DATA_W-1:0]  pickData;

  // Word address of the pixel under the beam: row * line length + column.
  always_comb begin
    scanAddr = ADDR_W'((32'(bus.scan_y >> V_SHIFT) * 32'(LINE_WORDS))
                       + 32'(bus.scan_x >> H_SHIFT));
  end

  // Round-robin pick: first requester after rrPtr, skipping whoever held
  // the port last cycle so a held request cannot be written twice.
  always_comb begin
    eligible  = bus.req & ~gntQ;
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = PTR_W'((int'(rrPtr) + off) % NUM_REQ);
      if (eligible[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  // Address and data of the winning client, sliced from the flat buses.
  always_comb begin
    pickAddr = bus.req_addr[int'(pickIdx)*ADDR_W +: ADDR_W];
    pickData = bus.req_data[int'(pickIdx)*DATA_W +: DATA_W];
  end

  // Port FSM: scanout read when in the active area, otherwise one granted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      rrPtr     <= PTR_W'(NUM_REQ - 1);
      gntQ      <= '0;
      memEnQ    <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
    end else if (bus.in_display) begin
      state    <= SCAN;
      gntQ     <= '0;
      memEnQ   <= 1'b1;
      memWeQ   <= 1'b0;
      memAddrQ <= scanAddr;
    end else begin
      state <= ARB;
      if (pickValid) begin
        gntQ      <= NUM_REQ'(1) << pickIdx;
        memEnQ    <= 1'b1;
        memWeQ    <= 1'b1;
        memAddrQ  <= pickAddr;
        memWdataQ <= pickData;
        rrPtr     <= pickIdx;
      end else begin
        gntQ   <= '0;
        memEnQ <= 1'b0;
        memWeQ <= 1'b0;
      end
    end
  end

  // Return path: a read on the port this cycle lands in pixel two edges after the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanReadQ   <= 1'b0;
      pixelQ      <= '0;
      pixelValidQ <= 1'b0;
    end else begin
      scanReadQ <= (state == SCAN);
      if (scanReadQ) begin
        pixelQ      <= bus.mem_rdata;
        pixelValidQ <= 1'b1;
      end else begin
        pixelValidQ <= 1'b0;
      end
    end
  end

  assign bus.gnt         = gntQ;
  assign bus.mem_en      = memEnQ;
  assign bus.mem_we      = memWeQ;
  assign bus.mem_addr    = memAddrQ;
  assign bus.mem_wdata   = memWdataQ;
  assign bus.pixel       = pixelQ;
  assign bus.pixel_valid = pixelValidQ;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: a behavioural VRAM, a reference model of
// the port schedule and returned pixels, directed scenarios with literal
// expectations and a randomized client/beam phase.
module tb_vram_port_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 15;
  localparam int LINE_WORDS = 160;
  localparam int H_SHIFT    = 3;
  localparam int V_SHIFT    = 2;
  localparam int MEM_SIZE   = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .LINE_WORDS(LINE_WORDS), .H_SHIFT(H_SHIFT), .V_SHIFT(V_SHIFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int displayRun  = 0;

  logic [DATA_W-1:0] vram     [MEM_SIZE];
  logic [DATA_W-1:0] modelMem [MEM_SIZE];

  // Reference model state.
  int                 rrPtrM;
  int                 lastGntM;
  logic [NUM_REQ-1:0] expGnt;
  logic               expEn;
  logic               expWe;
  logic [ADDR_W-1:0]  expAddr;
  logic [DATA_W-1:0]  expWdata;
  logic [DATA_W-1:0]  expPixel;
  logic               expValid;
  logic               s1v, s2v;
  logic [DATA_W-1:0]  s1d, s2d;
  logic               pendW;
  logic [ADDR_W-1:0]  pwAddr;
  logic [DATA_W-1:0]  pwData;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    rrPtrM   = NUM_REQ - 1;
    lastGntM = -1;
    expGnt   = '0;
    expEn    = 1'b0;
    expWe    = 1'b0;
    expAddr  = '0;
    expWdata = '0;
    expPixel = '0;
    expValid = 1'b0;
    s1v      = 1'b0;
    s2v      = 1'b0;
    s1d      = '0;
    s2d      = '0;
    pendW    = 1'b0;
    pwAddr   = '0;
    pwData   = '0;
  endtask

  task automatic modelStep();
    int found;
    int k;
    if (pendW) begin
      modelMem[pwAddr] = pwData;
      pendW = 1'b0;
    end
    if (s2v) begin
      expPixel = s2d;
      expValid = 1'b1;
    end else begin
      expValid = 1'b0;
    end
    s2v = s1v;
    s2d = s1d;
    s1v = 1'b0;
    if (bus.in_display) begin
      expGnt   = '0;
      expEn    = 1'b1;
      expWe    = 1'b0;
      expAddr  = ADDR_W'((((int'(bus.scan_y) >> V_SHIFT) * LINE_WORDS)
                          + (int'(bus.scan_x) >> H_SHIFT)) % MEM_SIZE);
      s1v      = 1'b1;
      s1d      = modelMem[expAddr];
      lastGntM = -1;
    end else begin
      found = -1;
      for (int off = 1; off <= NUM_REQ; off++) begin
        k = (rrPtrM + off) % NUM_REQ;
        if (found < 0 && bus.req[k] && k != lastGntM) found = k;
      end
      if (found >= 0) begin
        expGnt   = NUM_REQ'(1) << found;
        expEn    = 1'b1;
        expWe    = 1'b1;
        expAddr  = bus.req_addr[found*ADDR_W +: ADDR_W];
        expWdata = bus.req_data[found*DATA_W +: DATA_W];
        rrPtrM   = found;
        lastGntM = found;
        pendW    = 1'b1;
        pwAddr   = expAddr;
        pwData   = expWdata;
      end else begin
        expGnt   = '0;
        expEn    = 1'b0;
        expWe    = 1'b0;
        lastGntM = -1;
      end
    end
  endtask

  // Behavioural synchronous VRAM: one read or write per enabled cycle.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= vram[bus.mem_addr];
    end
  end

  // Reference model advances on every edge and resets with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  // Compare the port and pixel outputs against the model shortly after each edge.
  always @(posedge clk) begin
    #1;
    checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
    checkOutput("mem_en", 32'(bus.mem_en), 32'(expEn));
    checkOutput("mem_we", 32'(bus.mem_we), 32'(expWe));
    if (expEn) checkOutput("mem_addr", 32'(bus.mem_addr), 32'(expAddr));
    if (expWe) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(expWdata));
    checkOutput("pixel_valid", 32'(bus.pixel_valid), 32'(expValid));
    checkOutput("pixel", 32'(bus.pixel), 32'(expPixel));
  end

  task automatic setClient(input int c, input logic r, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.req[c] = r;
    bus.req_addr[c*ADDR_W +: ADDR_W] = a;
    bus.req_data[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic applyStimulus();
    for (int c = 0; c < NUM_REQ; c++) begin
      if (bus.gnt[c]) begin
        if ($urandom_range(0, 1) == 1)
          setClient(c, 1'b1, ADDR_W'($urandom_range(0, 19199)), DATA_W'($urandom));
        else
          bus.req[c] = 1'b0;
      end else if (bus.req[c]) begin
        if ($urandom_range(0, 15) == 0) bus.req[c] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        setClient(c, 1'b1, ADDR_W'($urandom_range(0, 19199)), DATA_W'($urandom));
      end
    end
    if (displayRun == 0) begin
      bus.in_display = ~bus.in_display;
      displayRun     = $urandom_range(1, 24);
    end else begin
      displayRun--;
    end
    bus.scan_x = 11'($urandom_range(0, 1279));
    bus.scan_y = 9'($urandom_range(0, 479));
  endtask

  // Directed scenarios followed by the randomized phase.
  initial begin
    logic [NUM_REQ-1:0] seq [5];
    int                 writes;
    int                 grants;
    int                 perClient [NUM_REQ];
    int                 bad;
    int                 hi, lo;

    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int a = 0; a < MEM_SIZE; a++) begin
      vram[a]     = DATA_W'(a ^ (a >> 7));
      modelMem[a] = DATA_W'(a ^ (a >> 7));
    end
    vram[19199]     = 8'hA5;
    modelMem[19199] = 8'hA5;

    bus.in_display = 1'b0;
    bus.scan_x     = '0;
    bus.scan_y     = '0;
    bus.req        = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Scanout address and two-edge pixel return.
    bus.in_display = 1'b1;
    bus.scan_x     = 11'd1278;
    bus.scan_y     = 9'd479;
    @(posedge clk); #2;
    checkOutput("scanAddr", 32'(bus.mem_addr), 32'd19199);
    checkOutput("scanWe", 32'(bus.mem_we), 32'd0);
    checkOutput("scanEn", 32'(bus.mem_en), 32'd1);
    checkOutput("modelScanAddr", 32'(expAddr), 32'd19199);
    @(posedge clk); #2;
    checkOutput("scanValidEarly", 32'(bus.pixel_valid), 32'd0);
    @(posedge clk); #2;
    checkOutput("scanPixel", 32'(bus.pixel), 32'hA5);
    checkOutput("scanValid", 32'(bus.pixel_valid), 32'd1);
    checkOutput("modelScanPixel", 32'(expPixel), 32'hA5);

    // Asynchronous reset mid-frame.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstGnt", 32'(bus.gnt), 32'd0);
    checkOutput("rstEn", 32'(bus.mem_en), 32'd0);
    checkOutput("rstWe", 32'(bus.mem_we), 32'd0);
    checkOutput("rstAddr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rstWdata", 32'(bus.mem_wdata), 32'd0);
    checkOutput("rstPixel", 32'(bus.pixel), 32'd0);
    checkOutput("rstValid", 32'(bus.pixel_valid), 32'd0);
    @(negedge clk);
    bus.in_display = 1'b0;
    for (int c = 0; c < NUM_REQ; c++) setClient(c, 1'b1, ADDR_W'(16'h100 + c), DATA_W'(8'h10 + c));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      checkOutput("rstSeqGnt", 32'(bus.gnt), 32'(seq[i]));
      checkOutput("rstSeqWe", 32'(bus.mem_we), 32'd1);
    end

    // Single held client: a write every other cycle.
    @(negedge clk);
    bus.req = '0;
    setClient(2, 1'b1, 15'h1234, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      checkOutput("singleGnt", 32'(bus.gnt), (i % 2 == 0) ? 32'b0100 : 32'b0000);
      if (i % 2 == 0) begin
        checkOutput("singleAddr", 32'(bus.mem_addr), 32'h1234);
        checkOutput("singleData", 32'(bus.mem_wdata), 32'h3C);
      end
    end
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (bus.mem_we && bus.mem_addr == 15'h1234) writes++;
      @(negedge clk);
      if (bus.gnt[2]) bus.req[2] = 1'b0;
    end
    checkOutput("singleOnce", 32'(writes), 32'd1);

    // Scanout preempts a pending request, which then completes unchanged.
    setClient(1, 1'b1, 15'h0ABC, 8'h5A);
    bus.in_display = 1'b1;
    bus.scan_x     = '0;
    bus.scan_y     = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      checkOutput("preemptGnt", 32'(bus.gnt), 32'd0);
      checkOutput("preemptWe", 32'(bus.mem_we), 32'd0);
    end
    @(negedge clk);
    bus.in_display = 1'b0;
    @(posedge clk); #2;
    checkOutput("preemptLateGnt", 32'(bus.gnt), 32'b0010);
    checkOutput("preemptLateAddr", 32'(bus.mem_addr), 32'h0ABC);
    checkOutput("preemptLateData", 32'(bus.mem_wdata), 32'h5A);

    // Fairness over a long blanking window.
    @(negedge clk);
    bus.req = '0;
    setClient(0, 1'b1, 15'h0010, 8'h01);
    setClient(1, 1'b1, 15'h0020, 8'h02);
    setClient(3, 1'b1, 15'h0030, 8'h03);
    writes = 0;
    grants = 0;
    for (int c = 0; c < NUM_REQ; c++) perClient[c] = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #2;
      if (bus.mem_we) writes++;
      for (int c = 0; c < NUM_REQ; c++) begin
        if (bus.gnt[c]) begin
          perClient[c]++;
          grants++;
        end
      end
    end
    hi = perClient[0];
    lo = perClient[0];
    foreach (perClient[c]) begin
      if (c != 2 && perClient[c] > hi) hi = perClient[c];
      if (c != 2 && perClient[c] < lo) lo = perClient[c];
    end
    checkOutput("fairSpreadOk", 32'(hi - lo <= 1), 32'd1);
    checkOutput("fairWrites", 32'(writes), 32'(grants));
    checkOutput("fairTotal", 32'(grants), 32'd256);
    checkOutput("fairIdleClient", 32'(perClient[2]), 32'd0);

    // Withdrawal: client 3 pulses while client 0 takes the slot.
    #1 rst_n = 1'b0;
    @(negedge clk);
    bus.req = '0;
    setClient(0, 1'b1, 15'h0001, 8'h11);
    setClient(3, 1'b1, 15'h7777, 8'h77);
    rst_n = 1'b1;
    @(posedge clk); #2;
    checkOutput("withdrawFirstGnt", 32'(bus.gnt), 32'b0001);
    @(negedge clk);
    bus.req = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (bus.gnt[3] || (bus.mem_we && bus.mem_addr == 15'h7777)) bad++;
    end
    checkOutput("withdrawNoWrite", 32'(bad), 32'd0);

    // Randomized clients, beam timing and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      applyStimulus();
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
